nec_frame_receiver: RTL and testbench

//  Front-end controller for the VCR remote decoder.
//  - Samples the demodulated IR line and times every mark/space.
//  - Walks the NEC leader, 32 data bits and repeat codes, shifting the bits into a 32-bit register.
//  - Hands the frame to an internal checksum_validator #(32).
//  - On a clean check, emits address/command with a strobe. Sits between the IR receiver pin and the command dispatcher.

---
 rtl/nec_frame_if.sv | 15 +
 rtl/nec_frame_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_nec_frame_receiver.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/nec_frame_if.sv
// Output bundle of the NEC frame receiver: decoded address/command, event strobes and FSM debug state.
interface nec_frame_if;
    // Strobes (o_valid, o_repeat, o_error) are single-cycle and carry no back-pressure.
    // The consumer samples o_addr/o_cmd in the o_valid cycle. There is no ready signal.
    logic [7:0] o_addr;
    logic [7:0] o_cmd;
    logic       o_valid;
    logic       o_repeat;
    logic       o_error;
    logic       o_busy;
    logic [2:0] dbg_state;

    modport master (output o_addr, o_cmd, o_valid, o_repeat, o_error, o_busy, dbg_state);
    modport slave  (input  o_addr, o_cmd, o_valid, o_repeat, o_error, o_busy, dbg_state);
endinterface

// File: rtl/nec_frame_receiver.sv
// NEC IR frame receiver: times marks/spaces of the synchronized IR line, walks leader/data/repeat,
// and validates the 32-bit frame with an internal complement checksum.
module checksum_validator #(
    parameter int W = 32
) (
    input  logic [W-1:0] frame,
    output logic         pass
);
    // Each 16-bit group is {~byte, byte}; every inverted byte must match its partner.
    always_comb begin
        pass = 1'b1;
        for (int i = 0; i < W / 16; i++) begin
            if (frame[16*i+8 +: 8] != ~frame[16*i +: 8]) pass = 1'b0;
        end
    end
endmodule

module nec_frame_receiver #(
    parameter int CLKS_PER_HALF_UNIT = 14063,
    parameter int CNT_W              = 6
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ir_n,
    nec_frame_if.master bus
);
    localparam int               PRE_W    = $clog2(CLKS_PER_HALF_UNIT + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_HALF_UNIT - 1);

    localparam logic [CNT_W-1:0] LM_MIN = CNT_W'(28);
    localparam logic [CNT_W-1:0] LM_MAX = CNT_W'(36);
    localparam logic [CNT_W-1:0] LS_MIN = CNT_W'(14);
    localparam logic [CNT_W-1:0] LS_MAX = CNT_W'(18);
    localparam logic [CNT_W-1:0] RP_MIN = CNT_W'(7);
    localparam logic [CNT_W-1:0] RP_MAX = CNT_W'(9);
    localparam logic [CNT_W-1:0] B_MIN  = CNT_W'(1);
    localparam logic [CNT_W-1:0] B_MAX  = CNT_W'(3);
    localparam logic [CNT_W-1:0] S1_MIN = CNT_W'(5);
    localparam logic [CNT_W-1:0] S1_MAX = CNT_W'(7);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        CHECK      = 3'd5
    } state_t;

    state_t           state;
    logic             ir_s1, ir_s2, ir_d;
    logic             fall, rise;
    logic [PRE_W-1:0] presc;
    logic [CNT_W-1:0] w;
    logic [CNT_W-1:0] phase_max;
    logic             timeout;
    logic [4:0]       bit_idx;
    logic [31:0]      sr;
    logic             have_frame;
    logic             chk_pass;
    logic [7:0]       addr_q, cmd_q;
    logic             valid_q, repeat_q, error_q;

    function automatic logic in_rng(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Delay flop resets high with the synchronizer so reset release never looks like an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ir_s1 <= 1'b1;
            ir_s2 <= 1'b1;
            ir_d  <= 1'b1;
        end else begin
            ir_s1 <= i_ir_n;
            ir_s2 <= ir_s1;
            ir_d  <= ir_s2;
        end
    end

    assign fall = ir_d & ~ir_s2;
    assign rise = ~ir_d & ir_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc <= '0;
            w     <= '0;
        end else if (fall || rise) begin
            presc <= '0;
            w     <= '0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
            if (w != '1) w <= w + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Non-measuring states get an all-ones limit, which w can never exceed.
    always_comb begin
        phase_max = '1;
        case (state)
            LEAD_MARK:  phase_max = LM_MAX;
            LEAD_SPACE: phase_max = LS_MAX;
            BIT_MARK:   phase_max = B_MAX;
            BIT_SPACE:  phase_max = S1_MAX;
            default:    phase_max = '1;
        endcase
        timeout = (w > phase_max);
    end

    checksum_validator #(.W(32)) u_chk (
        .frame (sr),
        .pass  (chk_pass)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            bit_idx    <= '0;
            sr         <= '0;
            have_frame <= 1'b0;
            addr_q     <= '0;
            cmd_q      <= '0;
            valid_q    <= 1'b0;
            repeat_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            repeat_q <= 1'b0;
            error_q  <= 1'b0;
            if (timeout) begin
                error_q    <= 1'b1;
                have_frame <= 1'b0;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: if (fall) state <= LEAD_MARK;
                    LEAD_MARK: if (rise) state <= (w >= LM_MIN) ? LEAD_SPACE : IDLE;
                    LEAD_SPACE: if (fall) begin
                        if (in_rng(w, LS_MIN, LS_MAX)) begin
                            bit_idx <= '0;
                            state   <= BIT_MARK;
                        end else if (in_rng(w, RP_MIN, RP_MAX) && have_frame) begin
                            repeat_q <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            error_q    <= 1'b1;
                            have_frame <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    BIT_MARK: if (rise) begin
                        if (in_rng(w, B_MIN, B_MAX)) begin
                            state <= BIT_SPACE;
                        end else begin
                            error_q    <= 1'b1;
                            have_frame <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    BIT_SPACE: if (fall) begin
                        if (in_rng(w, B_MIN, B_MAX) || in_rng(w, S1_MIN, S1_MAX)) begin
                            sr <= {in_rng(w, S1_MIN, S1_MAX), sr[31:1]};
                            if (bit_idx == 5'd31) begin
                                state <= CHECK;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                state   <= BIT_MARK;
                            end
                        end else begin
                            error_q    <= 1'b1;
                            have_frame <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    CHECK: begin
                        if (chk_pass) begin
                            addr_q     <= sr[7:0];
                            cmd_q      <= sr[23:16];
                            valid_q    <= 1'b1;
                            have_frame <= 1'b1;
                        end else begin
                            error_q    <= 1'b1;
                            have_frame <= 1'b0;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_addr    = addr_q;
    assign bus.o_cmd     = cmd_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_repeat  = repeat_q;
    assign bus.o_error   = error_q;
    assign bus.o_busy    = (state != IDLE);
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_nec_frame_receiver.sv
// Bench for nec_frame_receiver: drives NEC waveforms and scores every strobe against a frame-level model.
module tb_nec_frame_receiver;
    localparam int         C        = 4;
    localparam logic [1:0] K_VALID  = 2'd1;
    localparam logic [1:0] K_REPEAT = 2'd2;
    localparam logic [1:0] K_ERROR  = 2'd3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic ir_n  = 1'b1;

    nec_frame_if bus();

    nec_frame_receiver #(.CLKS_PER_HALF_UNIT(C), .CNT_W(6)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_ir_n  (ir_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [17:0] exp_q[$];
    logic [7:0]  m_addr = 8'h00;
    logic [7:0]  m_cmd  = 8'h00;
    bit          m_have = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: every strobe must match the head of the expected-event queue.
    logic [2:0]  mon_s;
    logic [1:0]  mon_k;
    logic [17:0] mon_got, mon_exp;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon_s = {bus.o_valid, bus.o_repeat, bus.o_error};
            if (mon_s != 3'b000) begin
                check("one_strobe", $countones(mon_s), 1);
                mon_k   = bus.o_valid ? K_VALID : (bus.o_repeat ? K_REPEAT : K_ERROR);
                mon_got = {mon_k, bus.o_addr, bus.o_cmd};
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {29'd0, mon_s}, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("event", {14'd0, mon_got}, {14'd0, mon_exp});
                end
            end
        end
    end

    task automatic hold(input logic lvl, input int hu);
        ir_n = lvl;
        repeat (hu * C) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] f);
        if (f[15:8] == ~f[7:0] && f[31:24] == ~f[23:16]) begin
            m_addr = f[7:0];
            m_cmd  = f[23:16];
            m_have = 1'b1;
            exp_q.push_back({K_VALID, m_addr, m_cmd});
        end else begin
            m_have = 1'b0;
            exp_q.push_back({K_ERROR, m_addr, m_cmd});
        end
        hold(1'b0, 32);
        hold(1'b1, 16);
        for (int i = 0; i < 32; i++) begin
            hold(1'b0, 2);
            hold(1'b1, f[i] ? 6 : 2);
        end
        hold(1'b0, 2);
        hold(1'b1, 20);
    endtask

    task automatic send_repeat();
        if (m_have) exp_q.push_back({K_REPEAT, m_addr, m_cmd});
        else exp_q.push_back({K_ERROR, m_addr, m_cmd});
        hold(1'b0, 32);
        hold(1'b1, 8);
        hold(1'b0, 2);
        hold(1'b1, 20);
    endtask

    // Leader plus nbits marks; the last mark is followed by a line held high forever.
    task automatic send_truncated(input int nbits);
        m_have = 1'b0;
        exp_q.push_back({K_ERROR, m_addr, m_cmd});
        hold(1'b0, 32);
        hold(1'b1, 16);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, 2);
            if (i < nbits - 1) hold(1'b1, ($urandom_range(0, 1) != 0) ? 6 : 2);
        end
        hold(1'b1, 30);
    endtask

    task automatic end_scenario(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
        check({tag, "_addr"}, {24'd0, bus.o_addr}, {24'd0, m_addr});
        check({tag, "_cmd"}, {24'd0, bus.o_cmd}, {24'd0, m_cmd});
    endtask

    initial begin
        logic [31:0] f;
        logic [7:0]  a, c;
        int          k;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", {24'd0, bus.o_addr}, 32'd0);
        check("rst_cmd", {24'd0, bus.o_cmd}, 32'd0);
        check("rst_strobes", {29'd0, bus.o_valid, bus.o_repeat, bus.o_error}, 32'd0);
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("rst_state", {29'd0, bus.dbg_state}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_repeat();
        end_scenario("rep_no_frame");

        send_frame(32'hBA45FF00);
        end_scenario("frame1");
        check("frame1_addr_const", {24'd0, bus.o_addr}, 32'h00);
        check("frame1_cmd_const", {24'd0, bus.o_cmd}, 32'h45);

        send_repeat();
        end_scenario("repeat");

        send_frame(32'hBB45FF00);
        end_scenario("bad_cmd");

        send_repeat();
        end_scenario("repeat_after_err");

        hold(1'b0, 5);
        hold(1'b1, 20);
        end_scenario("glitch");

        send_truncated(10);
        end_scenario("trunc");
        send_frame(32'hBA45FF00);
        end_scenario("after_trunc");

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_repeat();
            end else begin
                a = 8'($urandom);
                c = 8'($urandom);
                f = {~c, c, ~a, a};
                if ($urandom_range(0, 3) == 0) begin
                    k = int'($urandom_range(0, 31));
                    f[k] = ~f[k];
                end
                send_frame(f);
            end
            end_scenario("rand");
        end

        send_frame({~8'h34, 8'h34, ~8'h12, 8'h12});
        end_scenario("pre_reset");
        hold(1'b0, 32);
        hold(1'b1, 16);
        for (int i = 0; i < 5; i++) begin
            hold(1'b0, 2);
            hold(1'b1, 2);
        end
        hold(1'b0, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_addr", {24'd0, bus.o_addr}, 32'd0);
        check("midrst_cmd", {24'd0, bus.o_cmd}, 32'd0);
        check("midrst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("midrst_strobes", {29'd0, bus.o_valid, bus.o_repeat, bus.o_error}, 32'd0);
        m_addr = 8'h00;
        m_cmd  = 8'h00;
        m_have = 1'b0;
        exp_q.delete();
        ir_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 10);
        send_frame({~8'hC3, 8'hC3, ~8'h5A, 8'h5A});
        end_scenario("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        check("watchdog", 32'd1, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
